uart_tx_arbiter: RTL and testbench

- Shares one uart_tx serializer between N_REQ independent byte-stream requesters.
- Grants are round-robin at packet granularity, so a packet (bytes up to and including the one flagged last) is never interleaved with another requester's bytes.
- Sequences the serializer's start/done handshake one byte at a time.
- Sits between on-chip message sources (e.g. response formatter, debug printer) and the uart_tx instance driving the FPGA TX pin.

---
 rtl/uart_tx_arbiter.sv | 175 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one uart_tx serializer between N_REQ byte streams.
// Optional mid-packet starvation timeout is enabled by defining UART_TX_ARB_TIMEOUT_EN.
//
// state | meaning
// ARB   | no owner; grant first valid requester after ptr
// LOAD  | owner granted; wait for owner byte and an idle serializer
// START | start_o high for exactly one cycle
// WAIT  | byte in flight; done_i ignored on the first cycle
module uart_tx_arbiter #(
  parameter int N_REQ          = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [8*N_REQ-1:0] req_data_i,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [N_REQ-1:0]   req_last_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic [N_REQ-1:0]   grant_o,
  output logic [7:0]         data_o,
  output logic               start_o,
  input  logic               done_i,
  output logic               busy_o,
  output logic               timeout_o
);

  localparam int PW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
    $error("uart_tx_arbiter: N_REQ must be 2..8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("uart_tx_arbiter: TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {ARB = 2'd0, LOAD = 2'd1, START = 2'd2, WAIT = 2'd3} state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      owner_q, owner_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [7:0]         data_q, data_d;
  logic               start_q, start_d;
  logic               last_q, last_d;
  logic               wfirst_q, wfirst_d;

  logic [PW-1:0]      pick, cand;
  logic               found;
  logic               own_valid, own_last, handshake, to_hit;
  logic [7:0]         own_data;

  assign own_valid = req_valid_i[owner_q];
  assign own_last  = req_last_i[owner_q];
  assign own_data  = req_data_i[{owner_q, 3'b000} +: 8];
  assign handshake = (state_q == LOAD) && own_valid && done_i;

  // Search order ptr+1, ptr+2, ... wrapping; ptr itself is checked last.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = PW'((int'(ptr_q) + i) % N_REQ);
      if (!found && req_valid_i[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          starving;

  assign starving = (state_q == LOAD) && !own_valid && done_i;
  assign to_hit   = starving && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    to_cnt_d = '0;
    if (state_q == LOAD && !handshake && !to_hit)
      to_cnt_d = starving ? to_cnt_q + 1'b1 : to_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ARB;
      ptr_q    <= PW'(N_REQ - 1);
      owner_q  <= '0;
      grant_q  <= '0;
      data_q   <= 8'h00;
      start_q  <= 1'b0;
      last_q   <= 1'b0;
      wfirst_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      grant_q  <= grant_d;
      data_q   <= data_d;
      start_q  <= start_d;
      last_q   <= last_d;
      wfirst_q <= wfirst_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    grant_d  = grant_q;
    data_d   = data_q;
    start_d  = 1'b0;
    last_d   = last_q;
    wfirst_d = 1'b0;
    case (state_q)
      ARB: begin
        if (found) begin
          owner_d       = pick;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          state_d       = LOAD;
        end
      end
      LOAD: begin
        if (handshake) begin
          data_d  = own_data;
          last_d  = own_last;
          start_d = 1'b1;
          state_d = START;
        end else if (to_hit) begin
          ptr_d   = owner_q;
          grant_d = '0;
          state_d = ARB;
        end
      end
      START: begin
        wfirst_d = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        // uart_tx drops done_o one cycle after start, so the first WAIT cycle still reads idle.
        if (!wfirst_q && done_i) begin
          if (last_q) begin
            ptr_d   = owner_q;
            grant_d = '0;
            state_d = ARB;
          end else begin
            state_d = LOAD;
          end
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_comb begin
    req_ready_o = '0;
    if (state_q == LOAD) req_ready_o[owner_q] = own_valid && done_i;
    grant_o   = grant_q;
    data_o    = data_q;
    start_o   = start_q;
    busy_o    = (state_q != ARB);
    timeout_o = to_hit;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: queue-driven requesters, a behavioural uart_tx
// done/start model, and a round-robin packet-order model feeding a wire-byte scoreboard.
module tb_uart_tx_arbiter;

  localparam int CPB   = 10;
  localparam int FRAME = 10 * CPB;
`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req_data_i;
  logic [1:0]  req_valid_i, req_last_i, req_ready_o, grant_o;
  logic [7:0]  data_o;
  logic        start_o, done_i, busy_o, timeout_o;

  uart_tx_arbiter #(.N_REQ(2), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_data_i(req_data_i), .req_valid_i(req_valid_i), .req_last_i(req_last_i),
    .req_ready_o(req_ready_o), .grant_o(grant_o), .data_o(data_o),
    .start_o(start_o), .done_i(done_i), .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // requester byte queues: {last, byte}
  logic [8:0] src_q0[$], src_q1[$];
  logic [8:0] m_q0[$], m_q1[$];
  logic [7:0] mdl_out[$], exp_q[$], got_q[$];
  int         start_cyc[$];
  int         mdl_ptr = 1;
  int         cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic push0(input logic [7:0] b, input logic l);
    src_q0.push_back({l, b});
    m_q0.push_back({l, b});
  endtask

  task automatic push1(input logic [7:0] b, input logic l);
    src_q1.push_back({l, b});
    m_q1.push_back({l, b});
  endtask

  function automatic bit has(input int k);
    return (k == 0) ? (m_q0.size() > 0) : (m_q1.size() > 0);
  endfunction

  // Whole packets go out in round-robin order after the last-served requester.
  task automatic model_rr();
    int         k;
    logic [8:0] e;
    logic       end_pkt;
    mdl_out.delete();
    while (m_q0.size() > 0 || m_q1.size() > 0) begin
      k = (mdl_ptr + 1) % 2;
      if (!has(k)) k = mdl_ptr;
      end_pkt = 1'b0;
      while (!end_pkt && has(k)) begin
        if (k == 0) e = m_q0.pop_front();
        else        e = m_q1.pop_front();
        mdl_out.push_back(e[7:0]);
        end_pkt = e[8];
      end
      mdl_ptr = k;
    end
    foreach (mdl_out[i]) exp_q.push_back(mdl_out[i]);
  endtask

  // requesters and uart_tx done behaviour
  initial begin
    logic [1:0] rdy_s;
    logic       acc;
    int         ucnt;
    done_i = 1'b1; req_valid_i = '0; req_data_i = '0; req_last_i = '0; ucnt = 0;
    forever begin
      @(negedge clk);
      rdy_s = req_ready_o;
      acc   = start_o && done_i && !rst;
      @(posedge clk);
      #1;
      if (rdy_s[0] && src_q0.size() > 0) void'(src_q0.pop_front());
      if (rdy_s[1] && src_q1.size() > 0) void'(src_q1.pop_front());
      if (acc) begin
        done_i = 1'b0;
        ucnt   = FRAME;
      end else if (ucnt > 0) begin
        ucnt--;
        if (ucnt == 0) done_i = 1'b1;
      end
      req_valid_i[0] = src_q0.size() > 0;
      req_valid_i[1] = src_q1.size() > 0;
      req_data_i[7:0]  = (src_q0.size() > 0) ? src_q0[0][7:0] : 8'h00;
      req_last_i[0]    = (src_q0.size() > 0) ? src_q0[0][8]   : 1'b0;
      req_data_i[15:8] = (src_q1.size() > 0) ? src_q1[0][7:0] : 8'h00;
      req_last_i[1]    = (src_q1.size() > 0) ? src_q1[0][8]   : 1'b0;
    end
  end

  int         rdy_cnt0 = 0, rdy_cnt1 = 0, t_dr_last = 0, t_bfall = 0;
  logic [1:0] gr_last_start = '0, gr_at_r1 = '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
  int         to_cnt = 0, to_delta = 0, t_to = -100;
  logic [1:0] gr_after_to = '0;
`endif

  // per-cycle compare process
  initial begin
    logic       prev_start, prev_done, prev_busy, prev_hs;
    logic [7:0] prev_data, hs_byte;
    prev_start = 0; prev_done = 1; prev_busy = 0; prev_hs = 0; prev_data = 0; hs_byte = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_start = 0; prev_hs = 0;
        prev_data = data_o; prev_done = done_i; prev_busy = busy_o;
      end else begin
        chk("busy_vs_grant", busy_o, |grant_o);
        chk("grant_onehot0", $onehot0(grant_o), 1);
        chk("ready_owner_only", req_ready_o & ~(grant_o & req_valid_i), 0);
        if (req_ready_o != 0) chk("ready_needs_done", done_i, 1);
        chk("start_while_busy", start_o && !done_i, 0);
        chk("start_two_cycles", start_o && prev_start, 0);
        if (data_o !== prev_data) begin
          chk("data_change_no_hs", prev_hs, 1);
          chk("data_not_hs_byte", data_o, hs_byte);
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        if (timeout_o) begin
          to_cnt++;
          to_delta = cyc - t_dr_last;
          t_to = cyc;
        end
        if (cyc == t_to + 2) gr_after_to = grant_o;
`else
        chk("timeout_tied_low", timeout_o, 0);
`endif
        if (start_o) begin
          start_cyc.push_back(cyc);
          got_q.push_back(data_o);
          gr_last_start = grant_o;
          if (exp_q.size() == 0) chk("unexpected_start", data_o, 32'hFFFF_FFFF);
          else                   chk("wire_byte", data_o, exp_q.pop_front());
        end
        if (done_i && !prev_done) t_dr_last = cyc;
        if (prev_busy && !busy_o) t_bfall = cyc;
        if (req_ready_o[0]) rdy_cnt0++;
        if (req_ready_o[1]) begin
          rdy_cnt1++;
          gr_at_r1 = grant_o;
        end
        prev_hs    = (req_ready_o != 0);
        hs_byte    = req_ready_o[1] ? req_data_i[15:8] : req_data_i[7:0];
        prev_start = start_o; prev_data = data_o; prev_done = done_i; prev_busy = busy_o;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy_o && done_i && exp_q.size() == 0 && src_q0.size() == 0 && src_q1.size() == 0)
        break;
    end
    chk({name, "_reached_idle"}, i < 3000, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic idle_reset();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    mdl_ptr = 1;
  endtask

  initial begin
    int t_a, t_b, i;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_grant", grant_o, 0);
    chk("rst_ready", req_ready_o, 0);
    chk("rst_start", start_o, 0);
    chk("rst_data", data_o, 8'h00);
    chk("rst_busy", busy_o, 0);
    chk("rst_timeout", timeout_o, 0);
    step();
    rst = 1'b0;

    // single packet from requester 0
    step();
    rdy_cnt0 = 0; got_q.delete(); start_cyc.delete();
    push0(8'h41, 0); push0(8'h42, 1);
    model_rr();
    chk("model_single_len", mdl_out.size(), 2);
    if (mdl_out.size() == 2) chk("model_single", {mdl_out[0], mdl_out[1]}, 16'h4142);
    wait_idle("single");
    chk("single_bytes_sent", got_q.size(), 2);
    if (got_q.size() == 2) chk("single_wire", {got_q[0], got_q[1]}, 16'h4142);
    chk("single_ready_pulses", rdy_cnt0, 2);
    if (start_cyc.size() == 2) chk("single_byte_period", start_cyc[1] - start_cyc[0], 103);
    chk("single_grant_during", gr_last_start, 2'b01);
    chk("single_grant_after", grant_o, 2'b00);
    chk("single_busy_fall", t_bfall - t_dr_last, 1);

    // contention from a fresh pointer, then round-robin re-request
    idle_reset();
    got_q.delete();
    push0(8'h10, 0); push0(8'h11, 0); push0(8'h12, 1); push1(8'h20, 1);
    model_rr();
    chk("model_cont_len", mdl_out.size(), 4);
    if (mdl_out.size() == 4)
      chk("model_cont", {mdl_out[0], mdl_out[1], mdl_out[2], mdl_out[3]}, 32'h10111220);
    wait_idle("contention");
    chk("contention_count", got_q.size(), 4);

    step();
    got_q.delete();
    push0(8'h40, 1); push1(8'h30, 1);
    model_rr();
    chk("model_rr_len", mdl_out.size(), 2);
    if (mdl_out.size() == 2) chk("model_rr", {mdl_out[0], mdl_out[1]}, 16'h4030);
    wait_idle("rerequest");
    chk("rerequest_count", got_q.size(), 2);

    // non-owner held valid through a 3-byte packet
    step();
    rdy_cnt1 = 0; got_q.delete();
    push0(8'h60, 0); push0(8'h61, 0); push0(8'h62, 1); push1(8'h55, 1);
    model_rr();
    chk("model_hold_len", mdl_out.size(), 4);
    if (mdl_out.size() == 4)
      chk("model_hold", {mdl_out[0], mdl_out[1], mdl_out[2], mdl_out[3]}, 32'h60616255);
    wait_idle("hold");
    chk("hold_r1_pulses", rdy_cnt1, 1);
    chk("hold_r1_grant", gr_at_r1, 2'b10);
    chk("hold_count", got_q.size(), 4);

    // reset 25 cycles into the 0x41 frame; 0x42 then goes out as its own packet
    step();
    got_q.delete();
    src_q0.push_back({1'b0, 8'h41}); src_q0.push_back({1'b1, 8'h42});
    exp_q.push_back(8'h41); exp_q.push_back(8'h42);
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (got_q.size() > 0) break;
    end
    chk("rstmid_first_start", i < 300, 1);
    repeat (25) @(posedge clk);
    #1 rst = 1'b1;
    #2;
    chk("rstmid_grant", grant_o, 0);
    chk("rstmid_ready", req_ready_o, 0);
    chk("rstmid_start", start_o, 0);
    chk("rstmid_data", data_o, 8'h00);
    chk("rstmid_busy", busy_o, 0);
    chk("rstmid_timeout", timeout_o, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    mdl_ptr = 1;
    t_a = 0; t_b = 0;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (start_o) break;
      if (done_i) begin
        t_a = cyc;
        break;
      end
    end
    chk("rstmid_done_before_start", t_a != 0, 1);
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      if (start_o) begin
        t_b = cyc;
        break;
      end
    end
    chk("rstmid_start_after_done", t_b - t_a, 1);
    wait_idle("rstmid");
    chk("rstmid_count", got_q.size(), 2);
    mdl_ptr = 0;

`ifdef UART_TX_ARB_TIMEOUT_EN
    // requester 0 stalls mid-packet; requester 1 takes over after the timeout
    step();
    got_q.delete(); to_cnt = 0;
    src_q0.push_back({1'b0, 8'hAA});
    exp_q.push_back(8'hAA);
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      if (grant_o == 2'b01) break;
    end
    chk("to_grant0", i < 50, 1);
    step();
    src_q1.push_back({1'b1, 8'hBB});
    exp_q.push_back(8'hBB);
    wait_idle("timeout");
    chk("to_pulses", to_cnt, 1);
    chk("to_delta", to_delta, 16);
    chk("to_grant_switch", gr_after_to, 2'b10);
    chk("to_count", got_q.size(), 2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
